// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. A fetch PC issues one-cycle-latency
// requests to instruction memory; returned words are buffered with their PCs in
// a DEPTH-entry FIFO that feeds decode. A redirect flushes everything buffered
// or in flight and restarts fetching at the redirect target.
//
// Handshake: the decode side uses valid/ready. The head entry transfers on any
// rising edge where instr_valid and instr_ready are both high. instr_valid,
// instr and instr_pc depend only on registered state and never on instr_ready.
// The memory side has no back-pressure: a request in cycle N is answered on
// imem_rdata during cycle N+1 unconditionally.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic [31:0]     fifo_instr [DEPTH];
  logic [XLEN-1:0] fifo_pc    [DEPTH];

  logic            pop;
  logic            push;
  logic            space;
  logic [CW:0]     occupancy;

  // The low two bits of the redirect target are dropped to force alignment.
  logic            unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Occupancy counts buffered entries plus the slot reserved for the response
  // still in flight, so a push can never find the FIFO full.
  assign pop       = instr_valid & instr_ready;
  assign push      = inflight & ~redirect_en;
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign space     = occupancy < DEPTH_C;

  assign imem_req    = space & ~redirect_en & ~rst;
  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = fifo_instr[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];

  // Control state: fetch PC, in-flight tracking, FIFO pointers and count.
  // Redirect outranks every other update and discards the arriving response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect_en) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the next-generation pipelined core. It replaces the single-register PC-plus-combinational-ROM path with a fetch PC, a one-cycle-latency instruction-memory request interface and a DEPTH-entry instruction/PC FIFO feeding decode through a valid/ready handshake. Branch and jump redirects flush all buffered and in-flight fetches and restart fetching at the redirect target.

## Interface
- XLEN, 32: width of PC and address buses.
- DEPTH, 4: FIFO entries. Must be a power of two and at least 2.
- RESET_PC, 0: fetch PC loaded on reset. Must be 4-byte aligned.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  XLEN  fetch address; always equal to fetch_pc.
- imem_rdata  in  32  instruction returned in the cycle after a request.
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  decode accepts the head.
- instr  out  32  head instruction.
- instr_pc  out  XLEN  PC of the head instruction.
- redirect_en  in  1  flush and restart fetching.
- redirect_pc  in  XLEN  restart address; bits [1:0] are ignored and treated as 0.

## Operation
**State**
- fetch_pc: XLEN bits.
- FIFO: DEPTH entries of {instr, pc}, with read/write pointers of $clog2(DEPTH) bits that wrap naturally.
- count: $clog2(DEPTH+1) bits.
- inflight: 1 bit, plus inflight_pc.

**Control equations**
- pop = instr_valid & instr_ready.
- space = (count + inflight − pop) < DEPTH, evaluated at full width with no overflow.
- imem_req = space & !redirect_en & !rst.

**Request issue**
- Registers inflight = 1 and inflight_pc = fetch_pc.
- Advances fetch_pc by 4 (mod 2^XLEN); wrap-around from 0xFFFFFFFC to 0 is legal.

**Response**
- In the cycle when inflight = 1, imem_rdata is pushed together with inflight_pc.
- Push and pop in the same cycle leave count unchanged.
- Because space reserves the in-flight slot, a push never finds the FIFO full.

**Redirect (highest priority)**
- Clears the FIFO (count = 0, pointers reset) and sets inflight = 0.
- The response arriving that cycle is discarded.
- fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
- No request is issued in the redirect cycle.
- A pop that coincides with a redirect still counts as a completed handshake for decode; the FIFO is emptied regardless.

**Output and reset**
- instr_valid = (count != 0). instr and instr_pc always show the head entry.
- Reset values: fetch_pc = RESET_PC, count = 0, inflight = 0, pointers = 0.
  - imem_req = 0, imem_addr = RESET_PC, instr_valid = 0.
  - instr and instr_pc are don't-care while instr_valid = 0.
- Reset asserted mid-operation abandons every queued and in-flight fetch immediately (asynchronous). No stale instruction appears after reset release.

## Timing
- Request at cycle N → data pushed at the end of N+1 → instr_valid in cycle N+2. Minimum fetch-to-decode latency is 2 cycles.
- After reset release, the first cycle has imem_req = 1 at RESET_PC. That instruction is valid 2 cycles later.
- Redirect in cycle R → request at redirect_pc in R+1 → instr_valid in R+3.
- Steady state with instr_ready held at 1: one instruction per cycle, consecutive PCs, no bubbles.
- instr_ready low: requests continue until count + inflight = DEPTH, then imem_req = 0.
  - Raising instr_ready makes imem_req = 1 in that same cycle (combinational through pop).
- imem_req depends combinationally on instr_ready and redirect_en. There is no other input-to-output combinational path.

## Test plan
- **Reset/start-up**: hold rst for 3 cycles, imem_rdata = 0x00000013 + addr, instr_ready = 1.
  - Required: imem_req = 0 during reset.
  - Required: imem_addr sequence 0, 4, 8, …; instr_pc = 0 valid in the 2nd cycle after release; one instruction per cycle thereafter.
- **Backpressure with DEPTH = 4**: instr_ready = 0 for 10 cycles.
  - Required: exactly 4 requests (addr 0x0–0xC), count = 4, imem_req = 0 afterwards.
  - Release instr_ready: instr_pc 0x0, 0x4, 0x8, 0xC, 0x10 in consecutive cycles, with no duplicates or gaps.
- **Redirect with full FIFO**: redirect_en = 1, redirect_pc = 0x103.
  - Required: next cycle instr_valid = 0 and imem_addr = 0x100.
  - Required: first valid instr_pc = 0x100 three cycles after the redirect.
- **Redirect on a response cycle**: response for PC 0x8 arrives in the same cycle as a redirect to 0x40.
  - Required: the 0x8 instruction never appears on the output; the next instr_pc is 0x40.
- **PC wrap**: RESET_PC = 0xFFFFFFF8.
  - Required: instr_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- **Mid-operation reset**: pulse rst asynchronously between clock edges with the FIFO holding 3 entries.
  - Required: instr_valid = 0 and imem_addr = RESET_PC immediately.
  - Required: the first instruction after release is RESET_PC's.
